// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 memory stage: FSM encoding and byte-enable patterns.
package swt16_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MIS_LD2 = 2'd1,
        MIS_ST2 = 2'd2
    } mem_state_e;

    // Byte enables: bit 0 covers word bits [7:0], bit 1 covers bits [15:8].
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_FULL = 2'b11;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for 16-bit little-endian accesses: store enables/data per phase of a
// possibly split access, and reassembly of a split load from two word reads.
module mem_lane_align
    import swt16_pkg::*;
(
    input  logic        addr_lsb,  // A[0] of the access currently in M
    input  logic        phase,     // 0: first (word k) access, 1: second (word k+1) access
    input  logic [15:0] st_data,
    input  logic        ld_split,  // load in writeback was misaligned
    input  logic [15:0] rdata,
    input  logic [7:0]  lo_byte,   // rdata(k)[15:8] captured during the second read
    output logic [1:0]  be,
    output logic [15:0] wdata,
    output logic [15:0] ld_data
);

    // Select lanes for the store side and merge bytes for the load side.
    always_comb begin
        be    = BE_FULL;
        wdata = st_data;
        if (addr_lsb) begin
            if (!phase) begin
                // Low data byte lands in the high lane of word k.
                be    = BE_HI;
                wdata = {st_data[7:0], 8'h00};
            end else begin
                // High data byte lands in the low lane of word k+1.
                be    = BE_LO;
                wdata = {8'h00, st_data[15:8]};
            end
        end
        ld_data = ld_split ? {rdata[7:0], lo_byte} : rdata;
    end

endmodule

// File: rtl/mem_access.sv
// swt16 memory stage: registers exec outputs (M), drives the data-memory port, splits
// misaligned 16-bit accesses over two cycles with a one-cycle stall, and feeds writeback (W).
module mem_access
    import swt16_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_WIDTH = 12,
    parameter int unsigned DMEM_WORD_WIDTH = 16,
    parameter int unsigned IALU_WORD_WIDTH = 16,
    parameter int unsigned PC_WIDTH        = 12,
    parameter int unsigned PMEM_WORD_WIDTH = 16,
    parameter int unsigned REG_IDX_WIDTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rdata,
    output logic                       out_dmem_en,
    output logic                       out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-2:0] out_dmem_addr,
    output logic [1:0]                 out_dmem_be,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
    output logic                       out_stall,
    output logic                       out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc
);

    localparam int unsigned WordIdxW = DMEM_ADDR_WIDTH - 1;

    // M stage register
    logic                       m_load_q, m_store_q, m_wr_q;
    logic [DMEM_ADDR_WIDTH-1:0] m_rd_addr_q, m_wr_addr_q;
    logic [DMEM_WORD_WIDTH-1:0] m_wdata_q;
    logic [PMEM_WORD_WIDTH-1:0] m_instr_q;
    logic [PC_WIDTH-1:0]        m_pc_q;
    logic [IALU_WORD_WIDTH-1:0] m_res_q;
    logic [REG_IDX_WIDTH-1:0]   m_idx_q;

    // W stage register
    logic                       w_wr_q, w_load_q, w_split_q;
    logic [PMEM_WORD_WIDTH-1:0] w_instr_q;
    logic [PC_WIDTH-1:0]        w_pc_q;
    logic [IALU_WORD_WIDTH-1:0] w_res_q;
    logic [REG_IDX_WIDTH-1:0]   w_idx_q;

    mem_state_e state_q, state_d;
    logic [7:0] lo_byte_q;

    logic                       m_is_store, m_is_load, m_mem_op, m_mis, phase, stall_raw;
    logic [DMEM_ADDR_WIDTH-1:0] m_addr;
    logic [WordIdxW-1:0]        m_word;
    logic [1:0]                 lane_be;
    logic [15:0]                lane_wdata, lane_ld_data;

    // Decode the M-stage access; store wins when both flags are set.
    always_comb begin
        m_is_store = m_store_q;
        m_is_load  = m_load_q & ~m_store_q;
        m_mem_op   = m_is_store | m_is_load;
        m_addr     = m_is_store ? m_wr_addr_q : m_rd_addr_q;
        m_mis      = m_addr[0];
        m_word     = m_addr[DMEM_ADDR_WIDTH-1:1];
        phase      = (state_q != IDLE);
        stall_raw  = (state_q == IDLE) && m_mem_op && m_mis;
    end

    mem_lane_align u_lane (
        .addr_lsb (m_mis),
        .phase    (phase),
        .st_data  (m_wdata_q),
        .ld_split (w_split_q),
        .rdata    (in_dmem_rdata),
        .lo_byte  (lo_byte_q),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .ld_data  (lane_ld_data)
    );

    // Memory port, stall and writeback outputs; port controls are squashed while in reset.
    always_comb begin
        out_dmem_en    = ~reset & m_mem_op;
        out_dmem_we    = ~reset & m_is_store;
        out_dmem_be    = out_dmem_en ? lane_be : BE_NONE;
        // Word k+1 wraps naturally at the index width.
        out_dmem_addr  = phase ? m_word + 1'b1 : m_word;
        out_dmem_wdata = lane_wdata;
        out_stall      = ~reset & stall_raw;

        out_act_write_res_to_reg = w_wr_q;
        out_res                  = w_load_q ? lane_ld_data : w_res_q;
        out_res_reg_idx          = w_idx_q;
        out_instr                = w_instr_q;
        out_pc                   = w_pc_q;
    end

    // Split-access sequencer: first cycle stalls, second cycle issues word k+1.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (stall_raw) begin
                    state_d = m_is_store ? MIS_ST2 : MIS_LD2;
                end
            end
            MIS_LD2, MIS_ST2: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, M register (frozen while stalling) and low-byte capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            lo_byte_q   <= '0;
            m_load_q    <= 1'b0;
            m_store_q   <= 1'b0;
            m_wr_q      <= 1'b0;
            m_rd_addr_q <= '0;
            m_wr_addr_q <= '0;
            m_wdata_q   <= '0;
            m_instr_q   <= '0;
            m_pc_q      <= '0;
            m_res_q     <= '0;
            m_idx_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MIS_LD2) begin
                lo_byte_q <= in_dmem_rdata[15:8];
            end
            if (!stall_raw) begin
                m_load_q    <= in_act_load_dmem;
                m_store_q   <= in_act_store_dmem;
                m_wr_q      <= in_act_write_res_to_reg;
                m_rd_addr_q <= in_dmem_rd_addr;
                m_wr_addr_q <= in_dmem_wr_addr;
                m_wdata_q   <= in_dmem_wr_word;
                m_instr_q   <= in_instr;
                m_pc_q      <= in_pc;
                m_res_q     <= in_res;
                m_idx_q     <= in_res_reg_idx;
            end
        end
    end

    // W register: bubble during the stall cycle, otherwise take the M contents.
    always_ff @(posedge clock) begin
        if (reset || stall_raw) begin
            w_wr_q    <= 1'b0;
            w_load_q  <= 1'b0;
            w_split_q <= 1'b0;
            w_instr_q <= '0;
            w_pc_q    <= '0;
            w_res_q   <= '0;
            w_idx_q   <= '0;
        end else begin
            w_wr_q    <= m_wr_q;
            w_load_q  <= m_is_load;
            w_split_q <= m_is_load & m_mis;
            w_instr_q <= m_instr_q;
            w_pc_q    <= m_pc_q;
            w_res_q   <= m_res_q;
            w_idx_q   <= m_idx_q;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a byte-level reference memory predicts load results,
// and expected bus requests, stall cycles and writebacks are queued with their cycle.
module tb_mem_access;
    import swt16_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
    logic [11:0] in_dmem_rd_addr, in_dmem_wr_addr;
    logic [15:0] in_dmem_wr_word, in_instr, in_res, in_dmem_rdata;
    logic [11:0] in_pc;
    logic [3:0]  in_res_reg_idx;
    logic        out_dmem_en, out_dmem_we, out_stall, out_act_write_res_to_reg;
    logic [10:0] out_dmem_addr;
    logic [1:0]  out_dmem_be;
    logic [15:0] out_dmem_wdata, out_res, out_instr;
    logic [3:0]  out_res_reg_idx;
    logic [11:0] out_pc;

    mem_access dut (
        .clock                    (clock),
        .reset                    (reset),
        .in_act_load_dmem         (in_act_load_dmem),
        .in_act_store_dmem        (in_act_store_dmem),
        .in_act_write_res_to_reg  (in_act_write_res_to_reg),
        .in_dmem_rd_addr          (in_dmem_rd_addr),
        .in_dmem_wr_addr          (in_dmem_wr_addr),
        .in_dmem_wr_word          (in_dmem_wr_word),
        .in_instr                 (in_instr),
        .in_pc                    (in_pc),
        .in_res                   (in_res),
        .in_res_reg_idx           (in_res_reg_idx),
        .in_dmem_rdata            (in_dmem_rdata),
        .out_dmem_en              (out_dmem_en),
        .out_dmem_we              (out_dmem_we),
        .out_dmem_addr            (out_dmem_addr),
        .out_dmem_be              (out_dmem_be),
        .out_dmem_wdata           (out_dmem_wdata),
        .out_stall                (out_stall),
        .out_act_write_res_to_reg (out_act_write_res_to_reg),
        .out_res                  (out_res),
        .out_res_reg_idx          (out_res_reg_idx),
        .out_instr                (out_instr),
        .out_pc                   (out_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [1:0]  be;
        logic        chk_be;
        logic [15:0] wdata;
        int          cyc;
    } req_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  idx;
        logic [11:0] pc;
        int          cyc;
    } wb_t;

    req_t exp_req[$];
    wb_t  exp_wb[$];
    int   exp_stall[$];

    logic [15:0] dmem [2048];
    logic [7:0]  ref_mem [4096];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] pc_ctr = 12'h100;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Word-wide data memory with byte enables and registered read data.
    always @(posedge clock) begin
        if (out_dmem_en) begin
            if (out_dmem_we) begin
                if (out_dmem_be[0]) dmem[out_dmem_addr][7:0]  <= out_dmem_wdata[7:0];
                if (out_dmem_be[1]) dmem[out_dmem_addr][15:8] <= out_dmem_wdata[15:8];
            end else begin
                in_dmem_rdata <= dmem[out_dmem_addr];
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clock) begin
        req_t r;
        wb_t  w;
        int   s;
        if (reset) begin
            check_eq("rst_en", 32'(out_dmem_en), 32'd0);
            check_eq("rst_we", 32'(out_dmem_we), 32'd0);
            check_eq("rst_be", 32'(out_dmem_be), 32'd0);
            check_eq("rst_stall", 32'(out_stall), 32'd0);
        end else begin
            if (out_dmem_en) begin
                if (exp_req.size() == 0) begin
                    check_eq("req_spurious", 32'(out_dmem_en), 32'd0);
                end else begin
                    r = exp_req.pop_front();
                    check_eq("req_cyc", cyc, r.cyc);
                    check_eq("req_we", 32'(out_dmem_we), 32'(r.we));
                    check_eq("req_addr", 32'(out_dmem_addr), 32'(r.addr));
                    if (r.chk_be) check_eq("req_be", 32'(out_dmem_be), 32'(r.be));
                    if (r.we) check_eq("req_wdata", 32'(out_dmem_wdata), 32'(r.wdata));
                end
            end
            if (out_stall) begin
                if (exp_stall.size() == 0) begin
                    check_eq("stall_spurious", 32'(out_stall), 32'd0);
                end else begin
                    s = exp_stall.pop_front();
                    check_eq("stall_cyc", cyc, s);
                end
            end
            if (out_act_write_res_to_reg) begin
                if (exp_wb.size() == 0) begin
                    check_eq("wb_spurious", 32'(out_act_write_res_to_reg), 32'd0);
                end else begin
                    w = exp_wb.pop_front();
                    check_eq("wb_cyc", cyc, w.cyc);
                    check_eq("wb_res", 32'(out_res), 32'(w.res));
                    check_eq("wb_idx", 32'(out_res_reg_idx), 32'(w.idx));
                    check_eq("wb_pc", 32'(out_pc), 32'(w.pc));
                end
            end
        end
    end

    task automatic drive_nop();
        in_act_load_dmem        = 1'b0;
        in_act_store_dmem       = 1'b0;
        in_act_write_res_to_reg = 1'b0;
    endtask

    // Present one instruction, hold it through any stall; mcyc is its M-stage cycle.
    task automatic issue(input logic ld, input logic st, input logic wr, input logic [11:0] rd_a,
                         input logic [11:0] wr_a, input logic [15:0] d, input logic [15:0] res,
                         input logic [3:0] idx, output int waits, output int mcyc);
        logic s;
        @(negedge clock);
        in_act_load_dmem        = ld;
        in_act_store_dmem       = st;
        in_act_write_res_to_reg = wr;
        in_dmem_rd_addr         = rd_a;
        in_dmem_wr_addr         = wr_a;
        in_dmem_wr_word         = d;
        in_res                  = res;
        in_res_reg_idx          = idx;
        in_pc                   = pc_ctr;
        in_instr                = {4'hA, pc_ctr};
        waits = 0;
        s = out_stall;
        @(posedge clock);
        while (s && waits < 8) begin
            waits++;
            @(negedge clock);
            s = out_stall;
            @(posedge clock);
        end
        #1;
        mcyc = cyc;
        drive_nop();
    endtask

    // Issue an op and queue everything the reference model predicts for it.
    task automatic do_op(input logic ld, input logic st, input logic wr, input logic [11:0] rd_a,
                         input logic [11:0] wr_a, input logic [15:0] d, input logic [15:0] res,
                         input logic [3:0] idx, output int waits);
        logic        is_st, is_ld, mis;
        logic [11:0] a, a1;
        logic [10:0] k, k1;
        logic [15:0] val;
        logic [11:0] pcv;
        int          mc;
        is_st = st;
        is_ld = ld & ~st;
        a     = is_st ? wr_a : rd_a;
        a1    = a + 12'd1;
        mis   = a[0];
        k     = a[11:1];
        k1    = k + 11'd1;
        pcv   = pc_ctr;
        val   = res;
        issue(ld, st, wr, rd_a, wr_a, d, res, idx, waits, mc);
        pc_ctr = pc_ctr + 12'd1;
        if (is_st) begin
            ref_mem[a]  = d[7:0];
            ref_mem[a1] = d[15:8];
            if (!mis) begin
                exp_req.push_back('{1'b1, k, 2'b11, 1'b1, d, mc});
            end else begin
                exp_req.push_back('{1'b1, k, 2'b10, 1'b1, {d[7:0], 8'h00}, mc});
                exp_req.push_back('{1'b1, k1, 2'b01, 1'b1, {8'h00, d[15:8]}, mc + 1});
                exp_stall.push_back(mc);
            end
        end
        if (is_ld) begin
            val = {ref_mem[a1], ref_mem[a]};
            if (!mis) begin
                exp_req.push_back('{1'b0, k, 2'b11, 1'b1, 16'h0, mc});
            end else begin
                exp_req.push_back('{1'b0, k, 2'b00, 1'b0, 16'h0, mc});
                exp_req.push_back('{1'b0, k1, 2'b00, 1'b0, 16'h0, mc + 1});
                exp_stall.push_back(mc);
            end
        end
        if (wr) exp_wb.push_back('{val, idx, pcv, mc + (((is_ld | is_st) & mis) ? 2 : 1)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w, mc;
        logic [11:0] ra, wa;
        for (int i = 0; i < 2048; i++) dmem[i] = 16'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
        in_dmem_rdata   = 16'h0;
        in_dmem_rd_addr = '0;
        in_dmem_wr_addr = '0;
        in_dmem_wr_word = '0;
        in_res          = '0;
        in_res_reg_idx  = '0;
        in_pc           = '0;
        in_instr        = '0;
        drive_nop();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("reset_wr", 32'(out_act_write_res_to_reg), 32'd0);
        check_eq("reset_res", 32'(out_res), 32'd0);
        check_eq("reset_idx", 32'(out_res_reg_idx), 32'd0);
        check_eq("reset_pc", 32'(out_pc), 32'd0);
        check_eq("reset_stall", 32'(out_stall), 32'd0);
        check_eq("reset_en", 32'(out_dmem_en), 32'd0);

        // Aligned store then load of the same address.
        do_op(1'b0, 1'b1, 1'b0, 12'h000, 12'h010, 16'hBEEF, 16'h0, 4'd0, w);
        do_op(1'b1, 1'b0, 1'b1, 12'h010, 12'h000, 16'h0, 16'h0, 4'd5, w);
        check_eq("aligned_ld_waits", w, 0);
        // Misaligned store, misaligned load, dependent ALU op delayed by one cycle.
        do_op(1'b0, 1'b1, 1'b0, 12'h000, 12'h021, 16'h1234, 16'h0, 4'd0, w);
        do_op(1'b1, 1'b0, 1'b1, 12'h021, 12'h000, 16'h0, 16'h0, 4'd6, w);
        check_eq("mis_ld_waits", w, 1);
        do_op(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 16'h0, 16'h0077, 4'd7, w);
        check_eq("alu_after_mis_waits", w, 1);
        // Plain ALU result.
        repeat (2) @(posedge clock);
        do_op(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 16'h0, 16'h0042, 4'd3, w);
        check_eq("alu_waits", w, 0);
        // Wrapping misaligned store and its reload.
        do_op(1'b0, 1'b1, 1'b0, 12'h000, 12'hFFF, 16'hA55A, 16'h0, 4'd0, w);
        do_op(1'b1, 1'b0, 1'b1, 12'hFFF, 12'h000, 16'h0, 16'h0, 4'd9, w);
        // Both flags: the store address and data must win.
        do_op(1'b1, 1'b1, 1'b0, 12'h010, 12'h030, 16'h7788, 16'h0, 4'd0, w);
        do_op(1'b1, 1'b0, 1'b1, 12'h030, 12'h000, 16'h0, 16'h0, 4'd2, w);
        do_op(1'b1, 1'b0, 1'b1, 12'h010, 12'h000, 16'h0, 16'h0, 4'd4, w);

        // Reset during the second half of a misaligned load.
        issue(1'b1, 1'b0, 1'b1, 12'h021, 12'h000, 16'h0, 16'h0, 4'd8, w, mc);
        pc_ctr = pc_ctr + 12'd1;
        exp_req.push_back('{1'b0, 11'h010, 2'b00, 1'b0, 16'h0, mc});
        exp_stall.push_back(mc);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rst_split_fsm", 32'(dut.state_q), 32'(IDLE));
        check_eq("rst_split_wr", 32'(out_act_write_res_to_reg), 32'd0);
        check_eq("rst_split_en", 32'(out_dmem_en), 32'd0);
        check_eq("rst_split_stall", 32'(out_stall), 32'd0);

        // Random mix of ALU, loads, stores and dual-flag ops.
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            ra = 12'($urandom_range(0, 4095));
            wa = 12'($urandom_range(0, 4095));
            do_op(kind == 1 || kind == 3, kind >= 2, 1'($urandom_range(0, 1)), ra, wa,
                  16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), w);
        end

        repeat (6) @(posedge clock);
        @(negedge clock);
        check_eq("req_left", exp_req.size(), 0);
        check_eq("wb_left", exp_wb.size(), 0);
        check_eq("stall_left", exp_stall.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
